piso_tx: RTL and testbench

- Parallel-in, serial-out transmitter. Loads a WIDTH-bit word and shifts it out LSB first on `so`, one bit per clock.
- Bit order matches a right-shifting serial-in register (serial input enters at MSB). After WIDTH clocks such a receiver holds the original word.
- Provides a start/busy/done handshake so a controller can stream words back-to-back.

---
 rtl/piso_tx_if.sv | 14 +
 rtl/piso_tx.sv | 76 +++++++
 tb/tb_piso_tx.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/piso_tx_if.sv
// Handshake and data bundle between a word source and the piso_tx serializer.
// The master supplies words; the slave (piso_tx) drives the serial stream and status.
interface piso_tx_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] din;
  logic             so;
  logic             busy;
  logic             done;

  modport master (output load, din, input  so, busy, done);
  modport slave  (input  load, din, output so, busy, done);
endinterface

// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter: shifts a WIDTH-bit word out LSB first,
// with a busy flag while shifting and a one-cycle done pulse after the last bit.
module piso_tx #(
  parameter int WIDTH = 4,
  parameter int CW    = 3
) (
  input  logic     clk,
  input  logic     reset,
  piso_tx_if.slave bus
);

  typedef enum logic {IDLE, SHIFT} state_e;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned; otherwise a latch is inferred.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.load) begin
          shreg_d = bus.din;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Zero-fill from the top so the register is empty once the last bit has gone.
        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.so   = shreg_q[0];
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: directed vector table, multi-cycle corner cases,
// and randomized traffic compared against a queue-based reference model.
module tb_piso_tx;

  localparam int WIDTH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic [WIDTH-1:0] rx;

  int n_checks = 0;
  int n_pass   = 0;

  piso_tx_if #(.WIDTH(WIDTH)) bus ();

  piso_tx #(.WIDTH(WIDTH), .CW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Receiver: right-shifting serial-in register, serial input enters at the MSB.
  always @(posedge clk) rx <= {bus.so, rx[WIDTH-1:1]};

  typedef struct {
    logic             load;
    logic [WIDTH-1:0] din;
    logic             so;
    logic             busy;
    logic             done;
  } vec_t;

  typedef struct packed {
    logic so;
    logic busy;
    logic done;
  } out_t;

  out_t cur;
  out_t pending[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_out(input string name, input logic so, input logic busy, input logic done);
    check({name, ".so"},   8'(bus.so),   8'(so));
    check({name, ".busy"}, 8'(bus.busy), 8'(busy));
    check({name, ".done"}, 8'(bus.done), 8'(done));
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: an accepted word schedules WIDTH data cycles followed by one done cycle.
  task automatic model_edge(input logic ld, input logic [WIDTH-1:0] d);
    if (!cur.busy && ld) begin
      pending.delete();
      for (int k = 0; k < WIDTH; k++) pending.push_back('{so: d[k], busy: 1'b1, done: 1'b0});
      pending.push_back('{so: 1'b0, busy: 1'b0, done: 1'b1});
    end
    if (pending.size() > 0) cur = pending.pop_front();
    else                    cur = '0;
  endtask

  vec_t vecs[$];

  task automatic add(input logic ld, input logic [WIDTH-1:0] d,
                     input logic so, input logic busy, input logic done);
    vecs.push_back('{load: ld, din: d, so: so, busy: busy, done: done});
  endtask

  initial begin
    bit got_done;

    bus.load = 1'b0;
    bus.din  = '0;
    #12;
    check_out("reset", 1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    // Idle hold: din toggles with load low.
    for (int i = 0; i < 10; i++) begin
      bus.din = 4'(i[3:0] ^ 4'hA);
      step();
      check_out($sformatf("idle[%0d]", i), 1'b0, 1'b0, 1'b0);
    end

    // Basic word 1011.
    add(1, 4'b1011, 1, 1, 0);
    add(0, 4'b0000, 1, 1, 0);
    add(0, 4'b0000, 0, 1, 0);
    add(0, 4'b0000, 1, 1, 0);
    add(0, 4'b0000, 0, 0, 1);
    add(0, 4'b0000, 0, 0, 0);
    // Load while busy: second word 0111 is ignored.
    add(1, 4'b1001, 1, 1, 0);
    add(0, 4'b0000, 0, 1, 0);
    add(1, 4'b0111, 0, 1, 0);
    add(0, 4'b0000, 1, 1, 0);
    add(0, 4'b0000, 0, 0, 1);
    add(0, 4'b0000, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 0);
    // Back-to-back with load held high.
    add(1, 4'b1100, 0, 1, 0);
    add(1, 4'b1100, 0, 1, 0);
    add(1, 4'b1100, 1, 1, 0);
    add(1, 4'b1100, 1, 1, 0);
    add(1, 4'b1100, 0, 0, 1);
    add(1, 4'b0011, 1, 1, 0);
    add(1, 4'b0011, 1, 1, 0);
    add(1, 4'b0011, 0, 1, 0);
    add(1, 4'b0011, 0, 1, 0);
    add(0, 4'b0011, 0, 0, 1);
    add(0, 4'b0000, 0, 0, 0);

    foreach (vecs[i]) begin
      bus.load = vecs[i].load;
      bus.din  = vecs[i].din;
      step();
      check_out($sformatf("vec[%0d]", i), vecs[i].so, vecs[i].busy, vecs[i].done);
    end
    bus.load = 1'b0;

    // Loopback: receiver holds the word in the done cycle.
    bus.load = 1'b1;
    bus.din  = 4'b0110;
    step();
    bus.load = 1'b0;
    bus.din  = 4'b1111;
    got_done = 0;
    for (int i = 0; i < 10 && !got_done; i++) begin
      step();
      if (bus.done) got_done = 1;
    end
    check("loopback.done_seen", 8'(got_done), 8'd1);
    check("loopback.rx", 8'(rx), 8'b0110);
    step();

    // Reset mid-operation, asserted between edges after the 2nd bit.
    bus.load = 1'b1;
    bus.din  = 4'b1111;
    step();
    bus.load = 1'b0;
    step();
    check_out("pre_abort", 1'b1, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1;
    check_out("abort_now", 1'b0, 1'b0, 1'b0);
    step();
    check_out("abort_hold", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out($sformatf("after_abort[%0d]", i), 1'b0, 1'b0, 1'b0);
    end
    bus.load = 1'b1;
    bus.din  = 4'b0001;
    step();
    bus.load = 1'b0;
    check_out("restart[0]", 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < WIDTH; i++) begin
      step();
      check_out($sformatf("restart[%0d]", i), 1'b0, 1'b1, 1'b0);
    end
    step();
    check_out("restart.done", 1'b0, 1'b0, 1'b1);
    step();
    check_out("restart.idle", 1'b0, 1'b0, 1'b0);

    // Randomized traffic against the reference model, starting from idle.
    cur = '0;
    pending.delete();
    for (int i = 0; i < 300; i++) begin
      logic             ld;
      logic [WIDTH-1:0] d;
      ld = ($urandom_range(0, 9) < 4);
      d  = WIDTH'($urandom);
      bus.load = ld;
      bus.din  = d;
      model_edge(ld, d);
      step();
      check_out($sformatf("rand[%0d]", i), cur.so, cur.busy, cur.done);
    end
    bus.load = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
